// File: rtl/div_float.sv
// Multi-cycle IEEE-754 binary32 divider (q = a / b), restoring, one quotient bit per clock.
// Subnormals flush to zero; results truncate toward zero.
module div_float (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t      state, state_nx;
  logic [25:0] rem;
  logic [24:0] qm;
  logic [23:0] mb;
  logic [4:0]  cnt;
  logic [7:0]  ea, eb;
  logic        sign;
  logic        special;
  logic [31:0] special_q;

  logic        accept;
  logic        in_sign;
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic        in_special;
  logic [31:0] in_special_q;
  logic [25:0] diff;
  logic signed [9:0] e;
  logic [22:0] frac;
  logic [31:0] norm_q;

  // DONE also accepts a start, so back-to-back issue lands on the edge where done falls.
  assign accept = start && (state == IDLE || state == DONE);

  always_comb begin
    in_sign      = a[31] ^ b[31];
    a_zero       = (a[30:23] == 8'h00);
    b_zero       = (b[30:23] == 8'h00);
    a_inf        = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf        = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_nan        = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan        = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    in_special   = 1'b1;
    in_special_q = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      in_special_q = 32'h7FC0_0000;
    else if (a_inf || b_zero)
      in_special_q = {in_sign, 8'hFF, 23'h0};
    else if (a_zero || b_inf)
      in_special_q = {in_sign, 31'h0};
    else
      in_special = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Special results take the one-cycle NORM slot so q/done still register at E1.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? (in_special ? NORM : DIV) : IDLE;
      DIV:        if (cnt == 5'd24) state_nx = NORM;
      NORM:       state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIV) || (state == NORM);
    done = (state == DONE);
  end

  assign diff = rem - {2'b00, mb};

  always_comb begin
    e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    if (qm[24]) begin
      frac = qm[23:1];
    end else begin
      frac = qm[22:0];
      e    = e - 10'sd1;
    end
    if (special)         norm_q = special_q;
    else if (e >= 10'sd255) norm_q = {sign, 8'hFF, 23'h0};
    else if (e <= 10'sd0)   norm_q = {sign, 31'h0};
    else                    norm_q = {sign, e[7:0], frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       <= '0;
      qm        <= '0;
      mb        <= '0;
      cnt       <= '0;
      ea        <= '0;
      eb        <= '0;
      sign      <= 1'b0;
      special   <= 1'b0;
      special_q <= '0;
      q         <= '0;
    end else begin
      if (accept) begin
        rem       <= {2'b01, a[22:0]};
        mb        <= {1'b1, b[22:0]};
        qm        <= '0;
        cnt       <= '0;
        ea        <= a[30:23];
        eb        <= b[30:23];
        sign      <= in_sign;
        special   <= in_special;
        special_q <= in_special_q;
      end else if (state == DIV) begin
        if (rem >= {2'b00, mb}) begin
          qm  <= {qm[23:0], 1'b1};
          rem <= {diff[24:0], 1'b0};
        end else begin
          qm  <= {qm[23:0], 1'b0};
          rem <= {rem[24:0], 1'b0};
        end
        cnt <= cnt + 5'd1;
      end
      if (state == NORM) q <= norm_q;
    end
  end

endmodule

// File: tb/tb_div_float.sv
// Directed self-checking bench for div_float with a queue scoreboard of expected quotients.
module tb_div_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] q;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];

  div_float dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for done, then checks latency from E0, busy low, and q against the scoreboard.
  task automatic finish_op(input string tag, input int exp_lat, input int elapsed);
    int lat;
    logic [31:0] expv;
    lat = elapsed;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 80);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'h1, 32'h0);
    end else begin
      expv = exp_q.pop_front();
      chk({tag, "_q"}, q, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] expv, input int exp_lat);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    finish_op(tag, exp_lat, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_q", q, 32'h0);
    rst = 1'b0;

    run_op("div_7p5_2p5", 32'h40F0_0000, 32'h4020_0000, 32'h4040_0000, 26);
    run_op("div_1_3",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 26);
    run_op("div_m5p5_5",  32'hC0B0_0000, 32'h40A0_0000, 32'hBF8C_CCCC, 26);
    run_op("sp_3_0",      32'h4040_0000, 32'h0000_0000, 32'h7F80_0000, 1);
    run_op("sp_0_3",      32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 1);
    run_op("sp_0_0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1);
    run_op("sp_m1_0",     32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1);
    run_op("sp_nan",      32'h7FC0_0001, 32'h4040_0000, 32'h7FC0_0000, 1);
    run_op("sp_inf_inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1);
    run_op("sp_m3_inf",   32'hC040_0000, 32'h7F80_0000, 32'h8000_0000, 1);
    run_op("sp_denorm_a", 32'h0000_1234, 32'h4040_0000, 32'h0000_0000, 1);
    run_op("overflow",    32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 26);
    run_op("underflow",   32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 26);

    // Start pulsed mid-DIV with new operands must be ignored.
    @(negedge clk);
    start = 1'b1; a = 32'h40F0_0000; b = 32'h4020_0000;
    exp_q.push_back(32'h4040_0000);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'h3F80_0000; b = 32'h4040_0000;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("mid_div_start", 26, 6);

    // Reset during DIV aborts; no done for the aborted operation.
    @(negedge clk);
    start = 1'b1; a = 32'h3F80_0000; b = 32'h4040_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_q", q, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    chk("abort_q_held", q, 32'h0);

    run_op("after_abort_1_3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 26);
    run_op("back_to_back",    32'hC0B0_0000, 32'h40A0_0000, 32'hBF8C_CCCC, 26);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
